pipe_adder: RTL and testbench
=============================

Name: pipe_adder

Overview:
- Parametrised, pipelined ripple-segment adder.
- Adds two WIDTH-bit operands plus carry-in, processing SEG bits per pipeline stage.
- The carry is registered between stages, so timing closure is independent of WIDTH.
- Valid/ready handshakes on input and output give full throughput (one add per cycle) with backpressure.
- Used as the wide-arithmetic building block wherever the fixed 4-bit combinational adders no longer meet timing.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of SEG, ≥ SEG.
- SEG, 4, bits added per pipeline stage; STAGES = WIDTH/SEG.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands present
- in_ready  out  1  block accepts operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  a+b+cin modulo 2^WIDTH
- cout  out  1  carry out of bit WIDTH-1

Behaviour:
- Reset:
  - Async assert on rst_n low clears every stage valid bit and all data/carry registers to 0.
  - Outputs during reset and after release: out_valid=0, sum=0, cout=0, in_ready=1.
  - Deassertion is sampled synchronously by downstream logic; no extra sync inside.
- Pipeline: STAGES register stages; stage k (0-based) holds:
  - valid_k
  - the partial sum bits [k*SEG +: SEG] plus all lower bits already computed
  - carry_k out of segment k
  - the unprocessed upper operand bits of a and b, skewed/carried along
- Stage 0 adds a[SEG-1:0] + b[SEG-1:0] + cin.
- Stage k>0 adds its segment of the carried operands + carry_(k-1).
- Last stage drives sum/cout/out_valid directly from its registers; no output combinational path.
- Handshake (per-stage advance):
  - Last stage: ready_(S-1) = !valid_(S-1) | out_ready.
  - Other stages: ready_k = !valid_k | ready_(k+1).
  - in_ready = ready_0, a purely combinational function of valid bits and out_ready.
  - Transfer in on in_valid & in_ready; transfer out on out_valid & out_ready.
  - A stage loads when the upstream stage (or input) holds valid data and the stage itself is ready.
  - If its data advances and nothing replaces it, its valid bit clears.
  - Stage data registers load only when valid data advances into them; they hold otherwise.
- Latency: exactly STAGES cycles from accepted input to out_valid when out_ready stays high.
- Throughput: 1 result/cycle with out_ready=1.
- Capacity: STAGES results in flight.
- Backpressure:
  - With out_ready=0, the pipe compresses bubbles and in_ready drops once all stages are valid.
  - sum/cout/out_valid remain stable while out_valid & !out_ready.
- Simultaneous accept-in and emit-out on a full pipe is allowed (in_ready=1 when out_ready=1); no lost or duplicated results.
- Ordering: results emerge in acceptance order.
- Wrap-around: sum is modulo 2^WIDTH; the carry beyond it appears only on cout.
- Inputs a/b/cin are don't-care when in_valid=0.
- Mid-operation reset: all in-flight results are discarded, with no output of them after rst_n returns high.

Optional Feature:
- Macro: PIPE_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (out, 1) = signed two's-complement overflow of a+b+cin.
  - Computed in the last stage as carry into bit WIDTH-1 XOR cout.
  - Registered with sum, reset 0, stable under backpressure.
- Undefined: no ovf port and no extra registers; all other behaviour identical.

Decomposition:
- Shared package pipe_adder_pkg:
  - default WIDTH/SEG constants
  - function stage count (WIDTH/SEG)
  - elaboration-time check that WIDTH % SEG == 0
- One sub-module, pipe_adder_seg:
  - SEG-bit combinational add of two segments plus carry-in
  - returns SEG-bit sum and carry-out
  - instantiated once per stage by generate loop
- Valid/ready and register logic stay in the top.

Test Plan:
- Reset: hold rst_n=0 with random inputs → out_valid=0, sum=0x0000, cout=0, in_ready=1; release, idle 5 cycles → still out_valid=0.
- Single add (WIDTH=16, SEG=4), out_ready=1: a=0x00FF, b=0x0001, cin=0 accepted cycle 0 → out_valid exactly cycle 4, sum=0x0100, cout=0, single beat.
- Full carry ripple: a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1. Also a=0x8000, b=0x8000, cin=0 → sum=0x0000, cout=1.
- Throughput: 8 back-to-back random vectors, out_ready=1 → in_ready stays 1, results on 8 consecutive cycles (4..11), in order, matching a scoreboard.
- Backpressure: out_ready=0 while streaming → exactly 4 accepted, then in_ready=0. Output held stable ≥10 cycles. Raise out_ready → 4 results drain in order, with simultaneous new accepts; no loss or duplication.
- Mid-stream reset: pulse rst_n low with 3 results in flight → out_valid=0 immediately, no stale result after release. With PIPE_ADDER_OVF_EN: a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, ovf=1; a=0xFFFF, b=0x0001 → ovf=0, cout=1.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared defaults and elaboration helpers for pipe_adder.
package pipe_adder_pkg;
    localparam int WIDTH_DEF = 16;
    localparam int SEG_DEF = 4;
    function automatic int stage_count(input int width, input int seg);
        return width / seg;
    endfunction
    function automatic bit width_ok(input int width, input int seg);
        return seg > 0 && width >= seg && width % seg == 0;
    endfunction
endpackage

// File: rtl/pipe_adder_if.sv
// pipe_adder_if: operand/result handshake bundle; ovf exists only with PIPE_ADDER_OVF_EN.
interface pipe_adder_if
    import pipe_adder_pkg::*;
#(parameter int WIDTH = WIDTH_DEF);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef PIPE_ADDER_OVF_EN
    logic             ovf;
    modport master (output in_valid, a, b, cin, out_ready, input in_ready, out_valid, sum, cout, ovf);
    modport slave (input in_valid, a, b, cin, out_ready, output in_ready, out_valid, sum, cout, ovf);
`else
    modport master (output in_valid, a, b, cin, out_ready, input in_ready, out_valid, sum, cout);
    modport slave (input in_valid, a, b, cin, out_ready, output in_ready, out_valid, sum, cout);
`endif
endinterface

// File: rtl/pipe_adder_seg.sv
// pipe_adder_seg: SEG-bit combinational add of two segments plus carry-in.
module pipe_adder_seg
    import pipe_adder_pkg::*;
#(parameter int SEG = SEG_DEF) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};
endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: valid/ready pipelined adder, SEG bits per stage with registered carries.
// Define PIPE_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SEG = SEG_DEF
) (
    input logic       clk,
    input logic       rst_n,
    pipe_adder_if.slave bus
);
    localparam int STAGES = stage_count(WIDTH, SEG);

    if (!width_ok(WIDTH, SEG)) begin : g_chk
        $error("pipe_adder: WIDTH must be a positive multiple of SEG");
    end

    logic [STAGES-1:0] valid_d, valid_q, carry_d, carry_q, rdy, load;
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  up_a [STAGES];
    logic [WIDTH-1:0]  up_b [STAGES];
    logic [WIDTH-1:0]  up_s [STAGES];
    logic              up_v [STAGES];
    logic              up_c [STAGES];
    logic [SEG-1:0]    seg_s [STAGES];
    logic              seg_co [STAGES];
    logic              nxt;

    // Each stage sees either the input port or the previous stage's registers.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_in
            assign up_v[k] = bus.in_valid;
            assign up_c[k] = bus.cin;
            assign up_a[k] = bus.a;
            assign up_b[k] = bus.b;
            assign up_s[k] = '0;
        end else begin : g_chain
            assign up_v[k] = valid_q[k-1];
            assign up_c[k] = carry_q[k-1];
            assign up_a[k] = a_q[k-1];
            assign up_b[k] = b_q[k-1];
            assign up_s[k] = sum_q[k-1];
        end
        pipe_adder_seg #(.SEG(SEG)) u_seg (
            .a  (up_a[k][k*SEG +: SEG]),
            .b  (up_b[k][k*SEG +: SEG]),
            .ci (up_c[k]),
            .s  (seg_s[k]),
            .co (seg_co[k])
        );
    end

    always_comb begin
        nxt = bus.out_ready;
        rdy = '0;
        load = '0;
        valid_d = valid_q;
        carry_d = carry_q;
        sum_d = sum_q;
        a_d = a_q;
        b_d = b_q;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = !valid_q[k] | nxt;
            nxt = rdy[k];
            load[k] = up_v[k] & rdy[k];
            valid_d[k] = rdy[k] ? up_v[k] : valid_q[k];
            if (load[k]) begin
                sum_d[k] = up_s[k];
                sum_d[k][k*SEG +: SEG] = seg_s[k];
                carry_d[k] = seg_co[k];
                a_d[k] = up_a[k];
                b_d[k] = up_b[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k] <= '0;
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            sum_q <= sum_d;
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign bus.in_ready = rdy[0];
    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.sum = sum_q[STAGES-1];
    assign bus.cout = carry_q[STAGES-1];

`ifdef PIPE_ADDER_OVF_EN
    logic ovf_d, ovf_q;

    // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
    always_comb begin
        ovf_d = load[STAGES-1]
              ? up_a[STAGES-1][WIDTH-1] ^ up_b[STAGES-1][WIDTH-1] ^ seg_s[STAGES-1][SEG-1] ^ seg_co[STAGES-1]
              : ovf_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else ovf_q <= ovf_d;
    end

    assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed-vector bench for pipe_adder (WIDTH=16, SEG=4) with an in-order scoreboard.
module tb_pipe_adder;
    logic clk;
    logic rst_n;
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    int   rx_cnt = 0;
    int   stall_cnt = 0;
    int   cur = 0;
    int   q[$];
    int   out_cyc[$];
    bit   hold_prev = 0;
    logic [15:0] prev_sum;
    logic        prev_cout;

    localparam logic [15:0] VA  [12] = '{16'h1234, 16'hFFFF, 16'h8000, 16'hFFFF, 16'h00FF, 16'h0F0F,
                                         16'hABCD, 16'h7FFF, 16'h1000, 16'hFFFF, 16'h0000, 16'hC350};
    localparam logic [15:0] VB  [12] = '{16'h4321, 16'h0001, 16'h8000, 16'h0000, 16'h0001, 16'hF0F0,
                                         16'h1111, 16'h0001, 16'h2000, 16'hFFFF, 16'h0000, 16'h3CB0};
    localparam logic        VCI [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam logic [15:0] VS  [12] = '{16'h5555, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000,
                                         16'hBCDE, 16'h8000, 16'h3001, 16'hFFFF, 16'h0000, 16'h0000};
    localparam logic        VCO [12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam logic        VOV [12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    pipe_adder_if #(.WIDTH(16)) bus ();

    pipe_adder #(.WIDTH(16), .SEG(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Present vector i and return just after the edge that accepts it.
    task automatic send(input int i);
        bit ok = 0;
        bus.a = VA[i];
        bus.b = VB[i];
        bus.cin = VCI[i];
        bus.in_valid = 1'b1;
        cur = i;
        for (int t = 0; t < 32 && !ok; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1;
                @(posedge clk);
                #1;
            end
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev <= 0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
                check("hold_sum", {16'd0, bus.sum}, {16'd0, prev_sum});
                check("hold_cout", {31'd0, bus.cout}, {31'd0, prev_cout});
            end
            hold_prev <= bus.out_valid & !bus.out_ready;
            prev_sum <= bus.sum;
            prev_cout <= bus.cout;
            if (bus.in_valid && !bus.in_ready) stall_cnt++;
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(cur);
                acc_cnt++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_out", 32'd1, 32'd0);
                end else begin
                    int e;
                    e = q.pop_front();
                    check($sformatf("sum[%0d]", e), {16'd0, bus.sum}, {16'd0, VS[e]});
                    check($sformatf("cout[%0d]", e), {31'd0, bus.cout}, {31'd0, VCO[e]});
`ifdef PIPE_ADDER_OVF_EN
                    check($sformatf("ovf[%0d]", e), {31'd0, bus.ovf}, {31'd0, VOV[e]});
`endif
                    rx_cnt++;
                    out_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        int lat, k, acc0, rx0;
        bit taken;
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.a = 16'($urandom);
        bus.b = 16'($urandom);
        bus.cin = 1'($urandom);
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_sum", {16'd0, bus.sum}, 32'h0);
        check("rst_cout", {31'd0, bus.cout}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("idle_out_valid", {31'd0, bus.out_valid}, 32'd0);
        end

        // Single add: latency counted in edges from the accepting one.
        @(posedge clk);
        #1;
        send(4);
        bus.in_valid = 1'b0;
        lat = 1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bus.out_valid) break;
            @(posedge clk);
            lat++;
        end
        check("latency", lat, 32'd4);
        check("single_sum", {16'd0, bus.sum}, 32'h0100);
        check("single_cout", {31'd0, bus.cout}, 32'd0);
        @(negedge clk);
        check("single_beat", {31'd0, bus.out_valid}, 32'd0);

        // Back-to-back throughput.
        @(posedge clk);
        #1;
        out_cyc.delete();
        stall_cnt = 0;
        for (int i = 0; i < 8; i++) send(i);
        bus.in_valid = 1'b0;
        for (int t = 0; t < 30 && out_cyc.size() < 8; t++) @(negedge clk);
        check("tp_count", out_cyc.size(), 32'd8);
        if (out_cyc.size() == 8) check("tp_consecutive", out_cyc[7] - out_cyc[0], 32'd7);
        check("tp_stalls", stall_cnt, 32'd0);

        // Backpressure: fill, hold, then drain with simultaneous accepts.
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        k = 8;
        acc0 = acc_cnt;
        repeat (8) begin
            bus.a = VA[k % 12];
            bus.b = VB[k % 12];
            bus.cin = VCI[k % 12];
            bus.in_valid = 1'b1;
            cur = k % 12;
            @(negedge clk);
            taken = bus.in_ready;
            @(posedge clk);
            #1;
            if (taken) k++;
        end
        check("bp_accepted", acc_cnt - acc0, 32'd4);
        @(negedge clk);
        check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("bp_held_valid", {31'd0, bus.out_valid}, 32'd1);
        check("bp_held_sum", {16'd0, bus.sum}, {16'd0, VS[8]});
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send((k + i) % 12);
        bus.in_valid = 1'b0;
        for (int t = 0; t < 40 && (q.size() != 0 || bus.out_valid); t++) @(negedge clk);
        check("bp_drained", q.size(), 32'd0);
        check("bp_no_loss", rx_cnt, acc_cnt);

        // Mid-stream reset with three results in flight.
        @(posedge clk);
        #1;
        send(8);
        send(9);
        send(10);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        q.delete();
        rx0 = rx_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("mrst_no_stale", rx_cnt - rx0, 32'd0);
        check("mrst_idle_valid", {31'd0, bus.out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
